// File: rtl/seqtest_checker.sv
// LFSR-driven self-test checker: drives stim, waits LATENCY cycles, compares dut_out to ref_out.
// Define SEQTEST_STOP_ON_FAIL_EN to end a run at the first mismatching vector.
module seqtest_checker #(
    parameter int          WIDTH_IN    = 8,
    parameter int          WIDTH_OUT   = 8,
    parameter int          LATENCY     = 1,
    parameter int          NUM_VECTORS = 16384,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH_IN-1:0]  stim,
    output logic                 stim_valid,
    input  logic [WIDTH_OUT-1:0] dut_out,
    input  logic [WIDTH_OUT-1:0] ref_out,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [15:0]          vec_count,
    output logic [15:0]          err_count,
    output logic [15:0]          first_fail_vec,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] POLY     = 32'h80200003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [7:0]  LAT_LAST = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;
    localparam logic [15:0] NUM_VEC  = 16'(NUM_VECTORS);

`ifdef SEQTEST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    // stim_valid is a one-cycle strobe in DRIVE marking a fresh stim value; there is
    // no back-pressure, and stim stays stable until the following DRIVE.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? POLY : 32'h0);
    endfunction

    state_t      state, state_next;
    logic [31:0] lfsr;
    logic [31:0] lfsr_adv;
    logic [7:0]  wait_cnt;
    logic        launch;
    logic        mismatch;
    logic        last_vec;

    assign launch    = ((state == IDLE) || (state == DONE)) && start;
    assign mismatch  = (dut_out !== ref_out);
    assign last_vec  = ((vec_count + 16'd1) == NUM_VEC);
    assign lfsr_adv  = lfsr_step(launch ? SEED_EFF : lfsr);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE:   state_next = (LATENCY > 0) ? WAIT : CHECK;
            WAIT:    if (wait_cnt == LAT_LAST) state_next = CHECK;
            CHECK: begin
                if (last_vec || (STOP_ON_FAIL && mismatch)) state_next = DONE;
                else                                        state_next = DRIVE;
            end
            DONE:    if (start) state_next = DRIVE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        stim_valid = 1'b0;
        case (state)
            DRIVE: begin
                busy       = 1'b1;
                stim_valid = 1'b1;
            end
            WAIT, CHECK: busy = 1'b1;
            DONE:        done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr           <= SEED_EFF;
            stim           <= '0;
            wait_cnt       <= 8'd0;
            fail           <= 1'b0;
            vec_count      <= 16'd0;
            err_count      <= 16'd0;
            first_fail_vec <= 16'd0;
        end else begin
            if (launch) begin
                vec_count      <= 16'd0;
                err_count      <= 16'd0;
                fail           <= 1'b0;
                first_fail_vec <= 16'd0;
            end
            // The LFSR steps on entry to DRIVE so the new stim is visible with the strobe.
            if (state_next == DRIVE) begin
                lfsr <= lfsr_adv;
                stim <= lfsr_adv[WIDTH_IN-1:0];
            end
            if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
            else               wait_cnt <= 8'd0;
            if (state == CHECK) begin
                vec_count <= vec_count + 16'd1;
                if (mismatch) begin
                    fail <= 1'b1;
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    if (!fail) first_fail_vec <= vec_count;
                end
            end
        end
    end

endmodule

// File: tb/tb_seqtest_checker.sv
// Bench for seqtest_checker: two instances (LATENCY=0 and LATENCY=3) checked against
// a queue-based LFSR stimulus model and per-vector mismatch masks.
module tb_seqtest_checker;

    localparam int          NB     = 6;
    localparam logic [31:0] SEED_B = 32'hACE1;

    logic clk;
    logic rst_n;

    logic        start_a, sv_a, busy_a, done_a, fail_a;
    logic [7:0]  stim_a, dut_a, ref_a;
    logic [15:0] vc_a, ec_a, ffv_a;
    logic [2:0]  dbg_a;

    logic        start_b, sv_b, busy_b, done_b, fail_b;
    logic [7:0]  stim_b, dut_b, ref_b;
    logic [15:0] vc_b, ec_b, ffv_b;
    logic [2:0]  dbg_b;

    int   checks = 0;
    int   errors = 0;
    int   mode   = 0;
    int   pulse_cnt;
    logic bad_mask [NB];
    bit   stop_en;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] ref_seq[$];

    seqtest_checker #(.WIDTH_IN(8), .WIDTH_OUT(8), .LATENCY(0), .NUM_VECTORS(4), .SEED(32'h0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .stim_valid(sv_a),
        .dut_out(dut_a), .ref_out(ref_a), .busy(busy_a), .done(done_a), .fail(fail_a),
        .vec_count(vc_a), .err_count(ec_a), .first_fail_vec(ffv_a), .dbg_state(dbg_a)
    );

    seqtest_checker #(.WIDTH_IN(8), .WIDTH_OUT(8), .LATENCY(3), .NUM_VECTORS(NB), .SEED(SEED_B)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .stim_valid(sv_b),
        .dut_out(dut_b), .ref_out(ref_b), .busy(busy_b), .done(done_b), .fail(fail_b),
        .vec_count(vc_b), .err_count(ec_b), .first_fail_vec(ffv_b), .dbg_state(dbg_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_step(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if ((v & 32'h1) != 0) n = n ^ 32'h80200003;
        return n;
    endfunction

    task automatic fill_exp(input logic [31:0] seed, input int n);
        logic [31:0] m;
        m = (seed == 0) ? 32'h1 : seed;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            m = model_step(m);
            exp_q.push_back(m[7:0]);
        end
    endtask

    // The bench plays both the device under test and its golden model.
    assign ref_a = stim_a ^ 8'h33;
    assign dut_a = ref_a;

    always_comb begin
        ref_b = (mode == 2) ? 8'h5A : 8'(stim_b * 8'd7 + 8'd3);
        dut_b = ref_b;
        if (mode == 2)
            dut_b = 'x;
        else if (pulse_cnt >= 1 && pulse_cnt <= NB && bad_mask[pulse_cnt-1])
            dut_b = ref_b ^ 8'h01;
    end

    // pulse_cnt = index of the vector currently under test, plus one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pulse_cnt <= 0;
        else if (start_b && !busy_b) pulse_cnt <= 0;
        else if (sv_b)               pulse_cnt <= pulse_cnt + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic start_b_run();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    task automatic watch_b(input int budget, input int poke_cyc, output int pulses,
                           output int stim_errs, output int bad_gaps, output int cycles);
        int last;
        logic [7:0] e;
        pulses = 0; stim_errs = 0; bad_gaps = 0; cycles = 0; last = 0;
        obs_q.delete();
        while (!done_b && cycles < budget) begin
            if (sv_b) begin
                obs_q.push_back(stim_b);
                if (exp_q.size() == 0) stim_errs++;
                else begin
                    e = exp_q.pop_front();
                    if (stim_b !== e) stim_errs++;
                end
                if (pulses > 0 && cycles - last != 5) bad_gaps++;
                last = cycles;
                pulses++;
            end
            start_b = (cycles == poke_cyc) && busy_b;
            @(negedge clk);
            cycles++;
        end
        start_b = 1'b0;
    endtask

    // One run of instance B against a mismatch mask, with a start poke while busy.
    task automatic run_masked(input string name, input int poke_cyc);
        int first, n_run, exp_err, pulses, serr, gaps, cyc;
        first = -1;
        for (int i = NB - 1; i >= 0; i--) if (mode == 2 || bad_mask[i]) first = i;
        n_run = (stop_en && first >= 0) ? first + 1 : NB;
        exp_err = 0;
        for (int i = 0; i < n_run; i++) if (mode == 2 || bad_mask[i]) exp_err++;
        fill_exp(SEED_B, NB);
        start_b_run();
        watch_b(400, poke_cyc, pulses, serr, gaps, cyc);
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL %s done: got %0b want 1", name, done_b); end
        checks++; if (cyc !== 5 * n_run) begin errors++; $display("FAIL %s cycles: got %0d want %0d", name, cyc, 5 * n_run); end
        checks++; if (pulses !== n_run || gaps !== 0 || serr !== 0) begin
            errors++; $display("FAIL %s stim: pulses %0d want %0d, gaps %0d, stim errs %0d", name, pulses, n_run, gaps, serr);
        end
        checks++; if (vc_b !== 16'(n_run)) begin errors++; $display("FAIL %s vec_count: got %0d want %0d", name, vc_b, n_run); end
        checks++; if (ec_b !== 16'(exp_err)) begin errors++; $display("FAIL %s err_count: got %0d want %0d", name, ec_b, exp_err); end
        checks++; if (fail_b !== (first >= 0)) begin errors++; $display("FAIL %s fail: got %0b want %0b", name, fail_b, first >= 0); end
        checks++; if (ffv_b !== 16'((first >= 0) ? first : 0)) begin
            errors++; $display("FAIL %s first_fail_vec: got %0d want %0d", name, ffv_b, (first >= 0) ? first : 0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < NB; i++) bad_mask[i] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({stim_b, sv_b, busy_b, done_b, fail_b, vc_b, ec_b, ffv_b, dbg_b} !== '0) begin
            errors++; $display("FAIL reset_b outputs: got stim=%h sv=%b busy=%b done=%b fail=%b vc=%0d ec=%0d ffv=%0d st=%0d want all 0",
                               stim_b, sv_b, busy_b, done_b, fail_b, vc_b, ec_b, ffv_b, dbg_b);
        end
        checks++; if ({stim_a, sv_a, busy_a, done_a, fail_a, vc_a, ec_a, ffv_a, dbg_a} !== '0) begin
            errors++; $display("FAIL reset_a outputs: got stim=%h busy=%b vc=%0d st=%0d want all 0", stim_a, busy_a, vc_a, dbg_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy_b, done_b);
        end
    endtask

    task automatic test_latency0();
        logic [31:0] m;
        int cyc, pulses, serr;
        m = 32'h1; cyc = 0; pulses = 0; serr = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        while (!done_a && cyc < 100) begin
            if (sv_a) begin
                m = model_step(m);
                if (stim_a !== m[7:0]) serr++;
                pulses++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL lat0 cycles: got %0d want 8", cyc); end
        checks++; if (pulses !== 4 || serr !== 0) begin errors++; $display("FAIL lat0 stim: pulses %0d want 4, stim errs %0d want 0", pulses, serr); end
        checks++; if (vc_a !== 16'd4 || ec_a !== 16'd0 || fail_a !== 1'b0 || ffv_a !== 16'd0) begin
            errors++; $display("FAIL lat0 counters: got vc=%0d ec=%0d fail=%b ffv=%0d want 4 0 0 0", vc_a, ec_a, fail_a, ffv_a);
        end
        checks++; if (busy_a !== 1'b0 || dbg_a !== 3'd4) begin errors++; $display("FAIL lat0 state: got busy=%b st=%0d want 0 4", busy_a, dbg_a); end
    endtask

    task automatic test_pulses();
        int pulses, serr, gaps, cyc;
        mode = 0;
        for (int i = 0; i < NB; i++) bad_mask[i] = 1'b0;
        fill_exp(SEED_B, NB);
        start_b_run();
        watch_b(400, -1, pulses, serr, gaps, cyc);
        ref_seq = obs_q;
        checks++; if (pulses !== NB) begin errors++; $display("FAIL pulses count: got %0d want %0d", pulses, NB); end
        checks++; if (gaps !== 0 || serr !== 0) begin errors++; $display("FAIL pulses spacing/stim: gaps %0d stim errs %0d want 0 0", gaps, serr); end
        checks++; if (cyc !== 5 * NB || done_b !== 1'b1) begin errors++; $display("FAIL pulses cycles: got %0d done=%b want %0d 1", cyc, done_b, 5 * NB); end
        repeat (7) @(negedge clk);
        checks++; if (done_b !== 1'b1 || vc_b !== 16'(NB) || ec_b !== 16'd0 || fail_b !== 1'b0 || sv_b !== 1'b0) begin
            errors++; $display("FAIL done_hold: got done=%b vc=%0d ec=%0d fail=%b sv=%b want 1 %0d 0 0 0", done_b, vc_b, ec_b, fail_b, sv_b, NB);
        end
    endtask

    task automatic test_single_mismatch();
        mode = 0;
        for (int i = 0; i < NB; i++) bad_mask[i] = (i == 2);
        run_masked("single_mismatch", -1);
    endtask

    task automatic test_all_x();
        mode = 2;
        run_masked("all_x", -1);
        mode = 0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NB; i++) bad_mask[i] = ($urandom_range(0, 3) == 0);
            run_masked($sformatf("random%0d", r), $urandom_range(1, 12));
        end
    endtask

    task automatic test_reset_mid_wait();
        int cyc, pulses, serr, gaps;
        mode = 0;
        for (int i = 0; i < NB; i++) bad_mask[i] = 1'b0;
        start_b_run();
        cyc = 0;
        while (!(vc_b == 16'd1 && dbg_b == 3'd2) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (busy_b !== 1'b1 || dbg_b !== 3'd2) begin errors++; $display("FAIL mid_wait reached: got busy=%b st=%0d want 1 2", busy_b, dbg_b); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({stim_b, sv_b, busy_b, done_b, fail_b, vc_b, ec_b, ffv_b, dbg_b} !== '0) begin
            errors++; $display("FAIL async_reset: got stim=%h busy=%b vc=%0d st=%0d want all 0", stim_b, busy_b, vc_b, dbg_b);
        end
        repeat (4) @(negedge clk);
        checks++; if (vc_b !== 16'd0 || dbg_b !== 3'd0) begin errors++; $display("FAIL reset_hold: got vc=%0d st=%0d want 0 0", vc_b, dbg_b); end
        rst_n = 1'b1;
        @(negedge clk);
        fill_exp(SEED_B, NB);
        start_b_run();
        watch_b(400, -1, pulses, serr, gaps, cyc);
        checks++; if (obs_q != ref_seq || serr !== 0) begin
            errors++; $display("FAIL restart_seq: got %0d stims (%0d model errs) want identical %0d-stim sequence", obs_q.size(), serr, ref_seq.size());
        end
        checks++; if (vc_b !== 16'(NB) || ec_b !== 16'd0 || done_b !== 1'b1) begin
            errors++; $display("FAIL restart_run: got vc=%0d ec=%0d done=%b want %0d 0 1", vc_b, ec_b, done_b, NB);
        end
    endtask

    initial begin
`ifdef SEQTEST_STOP_ON_FAIL_EN
        stop_en = 1'b1;
`else
        stop_en = 1'b0;
`endif
        test_reset();
        test_latency0();
        test_pulses();
        test_single_mismatch();
        test_all_x();
        test_random();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
